// File: rtl/fs_accel_pkg.sv
// Shared types and constants for the accelerator filter-path weight loader.
// FSM state encoding plus kernel and byte-buffer geometry.
package fs_accel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } wl_state_e;

    localparam int K_ROWS         = 3;
    localparam int K_COLS         = 3;
    localparam int BYTES_PER_WORD = 4;
    localparam int WBUF_DEPTH     = 6;

endpackage

// File: rtl/fs_accel_wload_if.sv
// Word-stream handshake between the weight source and the weight loader.
// The source is the master; the loader is the slave.
interface fs_accel_wload_if;

    logic [31:0] wload_wdata;
    logic        wload_wvalid;
    logic        wload_wready;

    modport master (
        output wload_wdata,
        output wload_wvalid,
        input  wload_wready
    );

    modport slave (
        input  wload_wdata,
        input  wload_wvalid,
        output wload_wready
    );

endinterface

// File: rtl/fs_accel_wload_bytebuf.sv
// Six-byte oldest-first buffer: append four bytes at the tail, drop three
// from the head, both on the same edge if needed.
module fs_accel_wload_bytebuf
    import fs_accel_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [2:0]  cnt,
    output logic [23:0] head
);

    logic [7:0] byte_q [WBUF_DEPTH];
    logic [7:0] byte_d [WBUF_DEPTH];
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic [2:0] base;

    always_comb begin
        base = pop ? (cnt_q - 3'd3) : cnt_q;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            byte_d[i] = byte_q[i];
        end
        if (pop) begin
            byte_d[0] = byte_q[3];
            byte_d[1] = byte_q[4];
            byte_d[2] = byte_q[5];
            byte_d[3] = '0;
            byte_d[4] = '0;
            byte_d[5] = '0;
        end
        // Tail position is measured after the pop has shifted the head out.
        if (push) begin
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                for (int j = 0; j < BYTES_PER_WORD; j++) begin
                    if (i == int'(base) + j) begin
                        byte_d[i] = push_data[8*j +: 8];
                    end
                end
            end
        end
        cnt_d = base + (push ? 3'd4 : 3'd0);
        if (clear) begin
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                byte_d[i] = '0;
            end
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                byte_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                byte_q[i] <= byte_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign head = {byte_q[2], byte_q[1], byte_q[0]};

endmodule

// File: rtl/fs_accel_wload.sv
// Weight-load sequencer: unpacks 32-bit words into 3-byte kernel rows.
// Define FS_ACCEL_WLOAD_STAT_EN to add the wload_stall_cnt output.
module fs_accel_wload
    import fs_accel_pkg::*;
#(
    parameter int KCNT_W = 8,
    parameter int WCNT_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wload_start,
    input  logic [KCNT_W-1:0] wload_num_k,
    fs_accel_wload_if.slave   wif,
    output logic [7:0]        wload_do_0,
    output logic [7:0]        wload_do_1,
    output logic [7:0]        wload_do_2,
    output logic [1:0]        wload_sel,
    output logic              wload_row_we,
    output logic              wload_kdone,
    output logic              wload_busy,
    output logic              wload_done
`ifdef FS_ACCEL_WLOAD_STAT_EN
   ,output logic [15:0]       wload_stall_cnt
`endif
);

    localparam int PW = WCNT_W + 2;

    wl_state_e         state_q, state_d;
    logic [KCNT_W-1:0] num_k_q, num_k_d;
    logic [KCNT_W-1:0] kcnt_q, kcnt_d;
    logic [WCNT_W-1:0] wtot_q, wtot_d;
    logic [WCNT_W-1:0] wacc_q, wacc_d;
    logic [1:0]        row_q, row_d;
    logic [7:0]        do0_q, do0_d;
    logic [7:0]        do1_q, do1_d;
    logic [7:0]        do2_q, do2_d;
    logic [1:0]        sel_q, sel_d;
    logic              row_we_q, row_we_d;
    logic              kdone_q, kdone_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [2:0]        buf_cnt;
    logic [23:0]       buf_head;
    logic              wready;
    logic              accept;
    logic              emit;
    logic              last_row;
    logic              buf_clear;
    logic              start_ok;
    logic [PW-1:0]     prod;

    assign start_ok = (state_q == ST_IDLE) && wload_start;
    assign wready   = (state_q == ST_LOAD) && (buf_cnt <= 3'd2)
                      && (wacc_q < wtot_q);
    assign accept   = wready && wif.wload_wvalid;
    assign emit     = ((state_q == ST_LOAD) || (state_q == ST_FLUSH))
                      && (buf_cnt >= 3'd3);
    // The final row can leave while still in LOAD, right after the last word.
    assign last_row = emit && (row_q == 2'(K_ROWS - 1))
                      && (({1'b0, kcnt_q} + (KCNT_W+1)'(1))
                          == {1'b0, num_k_q});
    assign buf_clear = (state_q == ST_DONE) || start_ok;
    assign prod      = PW'(wload_num_k) * PW'(9) + PW'(3);

    fs_accel_wload_bytebuf u_bytebuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (buf_clear),
        .push      (accept),
        .pop       (emit),
        .push_data (wif.wload_wdata),
        .cnt       (buf_cnt),
        .head      (buf_head)
    );

    always_comb begin
        state_d  = state_q;
        num_k_d  = num_k_q;
        kcnt_d   = kcnt_q;
        wtot_d   = wtot_q;
        wacc_d   = wacc_q;
        row_d    = row_q;
        do0_d    = do0_q;
        do1_d    = do1_q;
        do2_d    = do2_q;
        sel_d    = sel_q;
        row_we_d = 1'b0;
        kdone_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (wload_start) begin
                    if (wload_num_k != '0) begin
                        num_k_d = wload_num_k;
                        wtot_d  = WCNT_W'(prod >> 2);
                        wacc_d  = '0;
                        kcnt_d  = '0;
                        row_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD, ST_FLUSH: begin
                if (accept) begin
                    wacc_d = wacc_q + WCNT_W'(1);
                end
                if (emit) begin
                    do0_d    = buf_head[7:0];
                    do1_d    = buf_head[15:8];
                    do2_d    = buf_head[23:16];
                    sel_d    = row_q;
                    row_we_d = 1'b1;
                    if (row_q == 2'(K_ROWS - 1)) begin
                        row_d   = '0;
                        kdone_d = 1'b1;
                        kcnt_d  = kcnt_q + KCNT_W'(1);
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
                if (last_row) begin
                    state_d = ST_DONE;
                end else if ((state_q == ST_LOAD)
                             && (wacc_q == wtot_q)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_LOAD) || (state_d == ST_FLUSH);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            num_k_q  <= '0;
            kcnt_q   <= '0;
            wtot_q   <= '0;
            wacc_q   <= '0;
            row_q    <= '0;
            do0_q    <= '0;
            do1_q    <= '0;
            do2_q    <= '0;
            sel_q    <= '0;
            row_we_q <= 1'b0;
            kdone_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_k_q  <= num_k_d;
            kcnt_q   <= kcnt_d;
            wtot_q   <= wtot_d;
            wacc_q   <= wacc_d;
            row_q    <= row_d;
            do0_q    <= do0_d;
            do1_q    <= do1_d;
            do2_q    <= do2_d;
            sel_q    <= sel_d;
            row_we_q <= row_we_d;
            kdone_q  <= kdone_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef FS_ACCEL_WLOAD_STAT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_ok) begin
            stall_d = '0;
        end else if (wready && !wif.wload_wvalid
                     && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign wload_stall_cnt = stall_q;
`endif

    assign wif.wload_wready = wready;
    assign wload_do_0       = do0_q;
    assign wload_do_1       = do1_q;
    assign wload_do_2       = do2_q;
    assign wload_sel        = sel_q;
    assign wload_row_we     = row_we_q;
    assign wload_kdone      = kdone_q;
    assign wload_busy       = busy_q;
    assign wload_done       = done_q;

endmodule

// File: tb/tb_fs_accel_wload.sv
// Directed and randomized bench for fs_accel_wload against a byte-stream model.
// Exercises wload_stall_cnt when FS_ACCEL_WLOAD_STAT_EN is defined.
module tb_fs_accel_wload;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_k = '0;
    logic [7:0] do_0, do_1, do_2;
    logic [1:0] sel;
    logic       row_we, kdone, busy, done;
`ifdef FS_ACCEL_WLOAD_STAT_EN
    logic [15:0] stall_cnt;
`endif

    int vec  = 0;
    int errs = 0;

    fs_accel_wload_if wif ();

    always #5 clk = ~clk;

    fs_accel_wload #(
        .KCNT_W (8),
        .WCNT_W (11)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wload_start     (start),
        .wload_num_k     (num_k),
        .wif             (wif),
        .wload_do_0      (do_0),
        .wload_do_1      (do_1),
        .wload_do_2      (do_2),
        .wload_sel       (sel),
        .wload_row_we    (row_we),
        .wload_kdone     (kdone),
        .wload_busy      (busy),
        .wload_done      (done)
`ifdef FS_ACCEL_WLOAD_STAT_EN
       ,.wload_stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_wready"}, wif.wload_wready, 0);
        check({tag, "_do"}, {do_2, do_1, do_0}, 0);
        check({tag, "_sel"}, sel, 0);
        check({tag, "_flags"}, {row_we, kdone, busy, done}, 0);
    endtask

    // Model: the word stream is a flat byte sequence; row r is bytes
    // 3r..3r+2, row select is r mod 3, bytes past 9*k are padding.
    task automatic run_load(input int k, input int gap_pct,
                            input int lead_idle, input int stop_rows,
                            input bit inc);
        logic [7:0]  b[$];
        logic [31:0] w[$];
        int nw, widx, rows, kd, dn, idle;
        bit take, fin, v;
        nw = (9 * k + 3) / 4;
        for (int i = 0; i < 4 * nw; i++) begin
            if (i < 9 * k) b.push_back(inc ? 8'(i + 1) : 8'($urandom));
            else           b.push_back(inc ? 8'h00 : 8'($urandom));
        end
        for (int j = 0; j < nw; j++)
            w.push_back({b[4*j+3], b[4*j+2], b[4*j+1], b[4*j]});
        @(negedge clk);
        start = 1'b1;
        num_k = 8'(k);
        @(negedge clk);
        start = 1'b0;
        num_k = 8'($urandom);
        widx = 0; rows = 0; kd = 0; dn = 0;
        idle = lead_idle; take = 0; fin = 0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (take) widx++;
            check("busy", busy, 32'(!done));
            if (row_we) begin
                if (rows < 3 * k) begin
                    check("row", {sel, do_2, do_1, do_0},
                          {2'(rows % 3), b[3*rows+2], b[3*rows+1], b[3*rows]});
                    check("kdone_row", kdone, 32'(rows % 3 == 2));
                end else begin
                    check("extra_row", 1, 0);
                end
                rows++;
            end
            if (kdone) kd++;
            if (done) dn++;
            if (wif.wload_wready) begin
                check("occupancy", 32'(4 * widx - 3 * rows <= 2), 1);
                check("wready_words", 32'(widx < nw), 1);
            end
            if (done || (stop_rows != 0 && rows >= stop_rows)) begin
                fin = 1;
            end else begin
                v = (widx < nw) && (idle == 0)
                    && ($urandom_range(99) >= 32'(gap_pct));
                if (idle > 0) idle--;
                wif.wload_wvalid = v;
                wif.wload_wdata  = v ? w[widx] : $urandom;
                take = v && wif.wload_wready;
                @(negedge clk);
            end
        end
        wif.wload_wvalid = 1'b0;
        if (!fin) check("timeout", 0, 1);
        if (stop_rows == 0) begin
            check("rows", rows, 3 * k);
            check("kdones", kd, k);
            check("dones", dn, 1);
            check("words", widx, nw);
            repeat (3) begin
                @(negedge clk);
                check("post_idle", {wif.wload_wready, row_we, busy, done}, 0);
            end
        end
    endtask

    initial begin
        int dn;
        wif.wload_wvalid = 1'b0;
        wif.wload_wdata  = '0;
        #12;
        check_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_load(1, 0, 0, 0, 1);
        run_load(4, 0, 0, 0, 1);
        run_load(2, 50, 0, 0, 0);
        run_load(2, 50, 0, 0, 1);

        @(negedge clk);
        start = 1'b1;
        num_k = 8'd0;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        repeat (3) begin
            if (done) dn++;
            check("k0_quiet", {wif.wload_wready, row_we}, 0);
            @(negedge clk);
        end
        check("k0_done", dn, 1);

        run_load(3, 0, 0, 5, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run_load(1, 0, 0, 0, 0);

        for (int t = 0; t < 4; t++) begin
            run_load(int'($urandom_range(6, 1)), int'($urandom_range(70)),
                     int'($urandom_range(3)), 0, 0);
        end

`ifdef FS_ACCEL_WLOAD_STAT_EN
        run_load(1, 0, 5, 0, 1);
        check("stall_cnt", stall_cnt, 5);
        @(negedge clk);
        start = 1'b1;
        num_k = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("stall_clr", stall_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/fs_accel_wload.md
Name: fs_accel_wload

Overview:
- Weight-load sequencer sitting directly upstream of the 3-row weight demux in the accelerator's filter path.
- Accepts a stream of 32-bit words carrying packed signed-8-bit 3x3 kernel weights, little-endian byte order, kernels contiguous.
- Unpacks the stream into 3-byte kernel rows and presents each row with a row select (0..2) and a one-cycle write strobe for the demux and weight registers.
- Counts kernels and signals completion to the accelerator controller.

Parameters:
- KCNT_W, 8, width of the kernel-count input and internal kernel counter.
- WCNT_W, 11, width of the accepted-word counter; must hold ceil(9*(2^KCNT_W-1)/4).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- wload_start  in  1  start pulse; sampled only in IDLE
- wload_num_k  in  KCNT_W  number of kernels to load; sampled with start
- wload_wdata  in  32  packed weights; byte0 = bits[7:0] is the earliest weight
- wload_wvalid  in  1  wdata valid
- wload_wready  out  1  word accepted on an edge where wvalid and wready are both high
- wload_do_0  out  8  row weight, column 0
- wload_do_1  out  8  row weight, column 1
- wload_do_2  out  8  row weight, column 2
- wload_sel  out  2  row index 0..2, drives demux select
- wload_row_we  out  1  one-cycle strobe; do_0..2 and sel valid
- wload_kdone  out  1  one-cycle pulse coincident with the row_we of row 2
- wload_busy  out  1  high in LOAD and FLUSH
- wload_done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: wready 0, do_0..2 0, sel 0, row_we 0, kdone 0, busy 0, done 0. All counters and the byte buffer are cleared.
- Reset asserted mid-operation aborts immediately to IDLE with the reset values above. No partial state survives.
- Byte buffer: 6 bytes with a 3-bit count. Bytes are ordered oldest-first.
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - On start with num_k != 0: latch num_k, compute words_total = (9*num_k + 3) >> 2, clear the counters, go to LOAD.
  - On start with num_k == 0: go to DONE directly.
  - start outside IDLE is ignored.
- wready = (state == LOAD) and (buffer count <= 2) and (words_acc < words_total). wready is combinational from registered state.
- Accept: appends 4 bytes at the buffer tail and increments words_acc.
- Emit: on any edge in LOAD/FLUSH where count >= 3 at the start of the cycle:
  - Register the oldest 3 bytes onto do_0/do_1/do_2 (oldest byte on do_0).
  - Set sel = row counter, pulse row_we, remove 3 bytes.
  - The row counter wraps 2 -> 0; on that wrap, pulse kdone and increment the kernel counter.
- Accept and emit may happen on the same edge. The new count is count - 3 + 4.
- Latency: a word accepted on edge k with no prior residue has row_we visible in the cycle after edge k+1.
- LOAD -> FLUSH when words_acc == words_total.
- FLUSH -> DONE on the edge that emits the final row (kernel counter reaches num_k). Leftover pad bytes (0..3) are discarded.
- DONE: pulse done for one cycle, clear the buffer, return to IDLE.
- No throttling of row output: the consumer is always ready.
- Arithmetic: words_total uses WCNT_W-bit unsigned arithmetic. The 9*num_k product is computed at WCNT_W+2 bits, no overflow.
- Outputs do_0..2 hold their last value between strobes. Consumers qualify them with row_we.

Optional Feature:
- Macro: FS_ACCEL_WLOAD_STAT_EN.
- With the macro defined:
  - Extra output wload_stall_cnt, 16 bits, counts cycles in LOAD with wready high and wvalid low.
  - It saturates at 0xFFFF, clears on start, and holds after done.
  - Reset value is 0.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package fs_accel_pkg holds:
  - the FSM state encoding (IDLE=0, LOAD=1, FLUSH=2, DONE=3);
  - K_ROWS=3 and K_COLS=3;
  - BYTES_PER_WORD=4 and WBUF_DEPTH=6.
- One natural sub-module, fs_accel_wload_bytebuf: the 6-byte shift/append buffer with count, push4/pop3 controls and simultaneous push/pop. The FSM and counters stay in the top module.

Test Plan:
- num_k=1, words 0x04030201, 0x08070605, 0x00000009 continuous -> three row_we:
  - (01,02,03) sel0;
  - (04,05,06) sel1;
  - (07,08,09) sel2 with kdone;
  - then done; exactly 3 words accepted; wready low afterwards.
- num_k=4, 9 words of incrementing bytes 0x01..0x24 -> 12 rows in order, sel cycling 0,1,2, kdone 4 times, done once; the 9th word is fully consumed with no pad.
- num_k=2, wvalid toggled randomly 50% -> same row sequence as the gap-free run; wready never high with buffer count > 2.
- start with num_k=0 -> done pulses within 2 cycles; no row_we; wready stays 0.
- Reset asserted mid-load (after 5 rows of num_k=3), then restarted with num_k=1 -> all outputs return to reset values; the new load produces the correct first row with sel=0.
- With FS_ACCEL_WLOAD_STAT_EN, num_k=1 and 5 idle wvalid-low cycles while wready is high -> stall_cnt=5 at done. A second start clears it to 0.
